// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : i2c_pkg
//  Description : Shared command/state encodings and frame constants for the
//                byte-level I2C/SCCB master engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    // Commands issued by the register sequencer
    typedef enum logic [1:0] {
        CMD_START = 2'd0,
        CMD_WRITE = 2'd1,
        CMD_READ  = 2'd2,
        CMD_STOP  = 2'd3
    } i2c_cmd_t;

    // Engine states; WRITE and READ share the BIT state
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BIT   = 2'd2,
        ST_STOP  = 2'd3
    } i2c_state_t;

    // Eight data bits plus the acknowledge bit
    localparam int I2C_BITS     = 9;
    // Tick quarters per SCL period
    localparam int I2C_QUARTERS = 4;

endpackage : i2c_pkg
`default_nettype wire

// File: rtl/i2c_byte_master.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_byte_master
//  Description : Byte-level I2C/SCCB master. Each command (START, WRITE,
//                READ, STOP) is accepted through a valid/ready handshake and
//                executed one tick quarter at a time, producing open-drain
//                SCL/SDA enables. Four ticks make one SCL bit period.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_byte_master
    import i2c_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic [7:0] wr_data,
    input  logic       rd_nack,
    output logic       done,
    output logic       err,
    output logic       ack_out,
    output logic [7:0] rd_data,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_i
);

    localparam logic [1:0] c_last_q   = 2'(I2C_QUARTERS - 1);
    localparam logic [3:0] c_last_bit = 4'(I2C_BITS - 1);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    i2c_state_t r_state;
    i2c_state_t w_state_nxt;

    logic [1:0] r_q;
    logic [3:0] r_bit;
    i2c_cmd_t   r_cmd;
    logic [7:0] r_wr_data;
    logic       r_rd_nack;
    logic       r_bus_active;
    logic       r_cmd_ready;
    logic       r_scl_oe;
    logic       r_sda_oe;
    logic       r_done;
    logic       r_err;
    logic       r_ack_smp;
    logic       r_ack_out;
    logic [7:0] r_rd_shift;
    logic [7:0] r_rd_data;

    // Next values of the registered outputs and bus-side state
    logic       w_scl_nxt;
    logic       w_sda_nxt;
    logic       w_done_nxt;
    logic       w_err_nxt;
    logic       w_bus_nxt;
    logic       w_ack_smp_nxt;
    logic       w_ack_nxt;
    logic [7:0] w_shift_nxt;
    logic [7:0] w_rd_nxt;

    // ------------------------------------------------------------------------
    // Handshake and sequencing decodes
    // ------------------------------------------------------------------------
    i2c_cmd_t   w_cmd_in;
    logic       w_accept;
    logic       w_legal;
    logic       w_step;
    logic       w_last_bit;
    logic       w_finish;
    logic [2:0] w_bit_idx;
    logic       w_bit_drive;

    assign w_cmd_in   = i2c_cmd_t'(cmd);
    assign w_accept   = cmd_valid && (r_state == ST_IDLE);
    // Only START may open a transaction; everything else needs an owned bus
    assign w_legal    = (w_cmd_in == CMD_START) || r_bus_active;
    // Ticks only advance an executing command, so a tick in the acceptance
    // cycle (state still IDLE) is naturally ignored
    assign w_step     = tick && (r_state != ST_IDLE);
    assign w_last_bit = (r_bit == c_last_bit);
    assign w_finish   = w_step && (r_q == c_last_q) &&
                        ((r_state != ST_BIT) || w_last_bit);

    // MSB first: bit n carries wr_data[7-n], which is the inverted low index
    assign w_bit_idx  = ~r_bit[2:0];

    // SDA pull-down for the current bit: data on WRITE, master ACK on READ
    assign w_bit_drive = w_last_bit ? ((r_cmd == CMD_READ)  ? ~r_rd_nack : 1'b0)
                                    : ((r_cmd == CMD_WRITE) ? ~r_wr_data[w_bit_idx] : 1'b0);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state selection: dispatch accepted legal commands, return on the last quarter
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_legal) begin
                    case (w_cmd_in)
                        CMD_START: w_state_nxt = ST_START;
                        CMD_STOP:  w_state_nxt = ST_STOP;
                        default:   w_state_nxt = ST_BIT;
                    endcase
                end
            end
            default: begin
                if (w_finish) begin
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    // Output decode: per-quarter bus actions and completion flags
    always_comb begin
        w_scl_nxt     = r_scl_oe;
        w_sda_nxt     = r_sda_oe;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        w_bus_nxt     = r_bus_active;
        w_ack_smp_nxt = r_ack_smp;
        w_ack_nxt     = r_ack_out;
        w_shift_nxt   = r_rd_shift;
        w_rd_nxt      = r_rd_data;

        case (r_state)
            ST_IDLE: begin
                // Illegal commands finish immediately without touching the bus
                if (w_accept && !w_legal) begin
                    w_done_nxt = 1'b1;
                    w_err_nxt  = 1'b1;
                end
            end

            ST_START: begin
                if (tick) begin
                    case (r_q)
                        2'd0: w_sda_nxt = 1'b0;
                        2'd1: w_scl_nxt = 1'b0;
                        2'd2: w_sda_nxt = 1'b1;
                        2'd3: begin
                            w_scl_nxt  = 1'b1;
                            w_bus_nxt  = 1'b1;
                            w_done_nxt = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end

            ST_BIT: begin
                if (tick) begin
                    case (r_q)
                        2'd0: w_sda_nxt = w_bit_drive;
                        2'd1: w_scl_nxt = 1'b0;
                        2'd2: begin
                            // Sample while SCL is high
                            if (w_last_bit) begin
                                if (r_cmd == CMD_WRITE) begin
                                    w_ack_smp_nxt = sda_i;
                                end
                            end else if (r_cmd == CMD_READ) begin
                                w_shift_nxt = {r_rd_shift[6:0], sda_i};
                            end
                        end
                        2'd3: begin
                            w_scl_nxt = 1'b1;
                            if (w_last_bit) begin
                                w_done_nxt = 1'b1;
                                // Results become visible together with done
                                if (r_cmd == CMD_WRITE) begin
                                    w_ack_nxt = r_ack_smp;
                                end else begin
                                    w_rd_nxt = r_rd_shift;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end

            ST_STOP: begin
                if (tick) begin
                    case (r_q)
                        2'd0: w_sda_nxt = 1'b1;
                        2'd1: w_scl_nxt = 1'b0;
                        2'd2: w_sda_nxt = 1'b0;
                        2'd3: begin
                            w_bus_nxt  = 1'b0;
                            w_done_nxt = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end

            default: ;
        endcase
    end

    // Datapath registers: command latch, counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q          <= 2'd0;
            r_bit        <= 4'd0;
            r_cmd        <= CMD_START;
            r_wr_data    <= 8'h00;
            r_rd_nack    <= 1'b0;
            r_bus_active <= 1'b0;
            r_cmd_ready  <= 1'b1;
            r_scl_oe     <= 1'b0;
            r_sda_oe     <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_ack_smp    <= 1'b1;
            r_ack_out    <= 1'b1;
            r_rd_shift   <= 8'h00;
            r_rd_data    <= 8'h00;
        end else begin
            r_scl_oe     <= w_scl_nxt;
            r_sda_oe     <= w_sda_nxt;
            r_done       <= w_done_nxt;
            r_err        <= w_err_nxt;
            r_bus_active <= w_bus_nxt;
            r_ack_smp    <= w_ack_smp_nxt;
            r_ack_out    <= w_ack_nxt;
            r_rd_shift   <= w_shift_nxt;
            r_rd_data    <= w_rd_nxt;
            r_cmd_ready  <= (w_state_nxt == ST_IDLE);

            if (w_accept) begin
                r_cmd     <= w_cmd_in;
                r_wr_data <= wr_data;
                r_rd_nack <= rd_nack;
                r_q       <= 2'd0;
                r_bit     <= 4'd0;
            end else if (w_step) begin
                r_q <= r_q + 2'd1;
                if ((r_state == ST_BIT) && (r_q == c_last_q)) begin
                    r_bit <= r_bit + 4'd1;
                end
            end
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign done      = r_done;
    assign err       = r_err;
    assign ack_out   = r_ack_out;
    assign rd_data   = r_rd_data;
    assign scl_oe    = r_scl_oe;
    assign sda_oe    = r_sda_oe;

endmodule : i2c_byte_master
`default_nettype wire

// File: tb/tb_i2c_byte_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_byte_master
//  Description : Self-checking bench for i2c_byte_master. A bus-level monitor
//                decodes start/stop conditions and 9-bit frames from the
//                open-drain lines and plays a simple slave; expected events
//                and results are derived from the commands issued.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_byte_master;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       tick      = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd       = 2'd0;
    logic [7:0] wr_data   = 8'h00;
    logic       rd_nack   = 1'b0;
    logic       cmd_ready;
    logic       done;
    logic       err;
    logic       ack_out;
    logic [7:0] rd_data;
    logic       scl_oe;
    logic       sda_oe;
    logic       sda_i;
    logic       slave_pull = 1'b0;

    assign sda_i = ~(sda_oe | slave_pull);

    i2c_byte_master dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .wr_data   (wr_data),
        .rd_nack   (rd_nack),
        .done      (done),
        .err       (err),
        .ack_out   (ack_out),
        .rd_data   (rd_data),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe),
        .sda_i     (sda_i)
    );

    always #5 clk = ~clk;

    localparam int EV_S = 1000;
    localparam int EV_P = 2000;

    int         n_cmp      = 0;
    int         n_bad      = 0;
    int         tick_cnt   = 0;
    bit         force_tick = 1'b0;
    int         mode       = 0;      // 0 passive, 1 write target, 2 read source
    bit         s_ack      = 1'b1;   // slave acknowledges writes
    logic [7:0] s_byte     = 8'h00;  // byte the slave returns on reads
    bit         bus_model  = 1'b0;   // expected bus ownership
    int         ev_q[$];
    int         exp_q[$];
    int         fb         = 0;
    logic [8:0] shreg      = 9'h000;
    bit         p_scl      = 1'b1;
    bit         p_sda      = 1'b1;
    logic       p_scl_oe   = 1'b0;
    logic       p_sda_oe   = 1'b0;
    int         act        = 0;

    // Random tick pulses, never on two consecutive cycles unless forced
    always @(negedge clk) begin
        if (force_tick)  tick = 1'b1;
        else if (tick)   tick = 1'b0;
        else             tick = ($urandom_range(0, 2) == 0);
    end

    always @(posedge clk) begin
        if (tick) tick_cnt <= tick_cnt + 1;
    end

    // Bus monitor and slave model working purely from line levels
    always @(negedge clk) begin
        bit scl_l;
        bit sda_l;
        int v;
        scl_l = ~scl_oe;
        sda_l = ~(sda_oe | slave_pull);
        if (reset) begin
            ev_q.delete();
            fb    = 0;
            shreg = 9'h000;
        end else if (scl_l && p_scl) begin
            if (p_sda && !sda_l) begin
                ev_q.push_back(EV_S);
                fb = 0;
            end else if (!p_sda && sda_l) begin
                ev_q.push_back(EV_P);
            end
        end else if (scl_l && !p_scl) begin
            shreg = {shreg[7:0], sda_l};
            if (fb == 8) begin
                v = int'(shreg[8:1]) + (shreg[0] ? 256 : 0);
                ev_q.push_back(v);
                fb = 0;
            end else begin
                fb = fb + 1;
            end
        end
        if ((scl_oe !== p_scl_oe) || (sda_oe !== p_sda_oe)) act = act + 1;
        p_scl_oe = scl_oe;
        p_sda_oe = sda_oe;
        p_scl    = scl_l;
        p_sda    = sda_l;
        if (reset || mode == 0)  slave_pull = 1'b0;
        else if (!scl_l) begin
            if (mode == 1)       slave_pull = (fb == 8) && s_ack;
            else                 slave_pull = (fb < 8) && !s_byte[7 - fb];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare decoded bus events against the expected sequence, then clear
    task automatic check_bus(input string tag);
        int n;
        chk({tag, "_nevents"}, ev_q.size(), exp_q.size());
        n = (ev_q.size() < exp_q.size()) ? ev_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s_ev%0d", tag, i), ev_q[i], exp_q[i]);
        ev_q.delete();
        exp_q.delete();
    endtask

    // Issue one command and check completion, latency, err and results.
    // now=1 drives the request immediately (used in the done cycle).
    task automatic do_cmd(input int c, input logic [7:0] d, input logic nk,
                          input bit now, input bit coincide, input string tag);
        bit legal;
        bit seen;
        int exp_ticks;
        int t0;
        int t1;
        int n;
        legal     = (c == 0) || bus_model;
        exp_ticks = !legal ? 0 : ((c == 1 || c == 2) ? 36 : 4);
        if (!now) begin
            n = 0;
            do begin
                @(posedge clk);
                #1;
                n++;
            end while (!cmd_ready && n < 2000);
        end
        mode       = (legal && (c == 1 || c == 2)) ? c : 0;
        cmd_valid  = 1'b1;
        cmd        = c[1:0];
        wr_data    = d;
        rd_nack    = nk;
        force_tick = coincide;
        @(posedge clk);
        #1;
        t0         = tick_cnt;
        cmd_valid  = 1'b0;
        force_tick = 1'b0;
        chk({tag, "_ready_after_accept"}, cmd_ready, legal ? 0 : 1);
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        t1 = tick_cnt;
        chk({tag, "_done"}, seen, 1);
        chk({tag, "_ticks"}, t1 - t0, exp_ticks);
        chk({tag, "_err"}, err, legal ? 0 : 1);
        if (legal) begin
            case (c)
                0: begin
                    bus_model = 1'b1;
                    exp_q.push_back(EV_S);
                end
                1: begin
                    exp_q.push_back(int'(d) + (s_ack ? 0 : 256));
                    chk({tag, "_ack_out"}, ack_out, s_ack ? 0 : 1);
                end
                2: begin
                    exp_q.push_back(int'(s_byte) + (nk ? 256 : 0));
                    chk({tag, "_rd_data"}, rd_data, s_byte);
                end
                default: begin
                    bus_model = 1'b0;
                    exp_q.push_back(EV_P);
                end
            endcase
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int         a0;
        int         n;
        int         nd;
        logic [7:0] rb;
        bit         rn;

        // ---------------- reset values ----------------
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scl_oe",    scl_oe,    0);
        chk("rst_sda_oe",    sda_oe,    0);
        chk("rst_cmd_ready", cmd_ready, 1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_done",    done,    0);
        chk("rst_err",     err,     0);
        chk("rst_ack_out", ack_out, 1);
        chk("rst_rd_data", rd_data, 8'h00);

        // ---------------- START (tick coincident with accept) then WRITE 0x42 ----------------
        s_ack = 1'b1;
        do_cmd(0, 8'h00, 1'b0, 1'b0, 1'b1, "start_coinc");
        do_cmd(1, 8'h42, 1'b0, 1'b0, 1'b0, "wr42");
        chk("hold_scl_between", scl_oe, 1);
        check_bus("seq42");

        // ---------------- WRITE NACK ----------------
        s_ack = 1'b0;
        do_cmd(1, 8'hA5, 1'b0, 1'b0, 1'b0, "wrA5_nack");

        // ---------------- READ 0x3C with NACK, then STOP in the done cycle ----------------
        s_byte = 8'h3C;
        do_cmd(2, 8'h00, 1'b1, 1'b0, 1'b0, "rd3C");
        chk("rd3C_sda_released", sda_oe, 0);
        do_cmd(3, 8'h00, 1'b0, 1'b1, 1'b0, "stop_b2b");
        chk("stop_scl_rel", scl_oe, 0);
        chk("stop_sda_rel", sda_oe, 0);
        check_bus("seq_rd");

        // ---------------- Illegal READ on an idle bus ----------------
        a0 = act;
        do_cmd(2, 8'h00, 1'b0, 1'b0, 1'b0, "illegal_rd");
        repeat (5) @(negedge clk);
        chk("illegal_activity", act - a0, 0);
        chk("illegal_scl", scl_oe, 0);
        check_bus("seq_illegal");

        // ---------------- Repeated start ----------------
        s_ack  = 1'b1;
        s_byte = 8'($urandom);
        rn     = 1'($urandom);
        do_cmd(0, 8'h00, 1'b0, 1'b0, 1'b0, "rs_start1");
        do_cmd(1, 8'h43, 1'b0, 1'b0, 1'b0, "rs_wr43");
        do_cmd(0, 8'h00, 1'b0, 1'b1, 1'b0, "rs_start2");
        do_cmd(2, 8'h00, rn,   1'b0, 1'b0, "rs_rd");
        do_cmd(3, 8'h00, 1'b0, 1'b0, 1'b0, "rs_stop");
        check_bus("seq_rs");

        // ---------------- Randomized transactions ----------------
        for (int k = 0; k < 3; k++) begin
            s_ack  = 1'($urandom);
            s_byte = 8'($urandom);
            rb     = 8'($urandom);
            rn     = 1'($urandom);
            do_cmd(0, 8'h00, 1'b0, 1'($urandom), 1'($urandom), $sformatf("rnd%0d_start", k));
            do_cmd(1, rb,    1'b0, 1'($urandom), 1'b0, $sformatf("rnd%0d_wr", k));
            do_cmd(2, 8'h00, rn,   1'($urandom), 1'b0, $sformatf("rnd%0d_rd", k));
            do_cmd(3, 8'h00, 1'b0, 1'($urandom), 1'b0, $sformatf("rnd%0d_stop", k));
            check_bus($sformatf("seq_rnd%0d", k));
        end

        // ---------------- Asynchronous reset during bit 3 of a WRITE ----------------
        s_ack = 1'b1;
        do_cmd(0, 8'h00, 1'b0, 1'b0, 1'b0, "rst_start");
        @(posedge clk);
        #1;
        mode      = 1;
        cmd_valid = 1'b1;
        cmd       = 2'd1;
        wr_data   = 8'h96;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        n = 0;
        while (fb < 4 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rst_reach_bit3", (n < 2000), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_scl", scl_oe, 0);
        chk("rst_mid_sda", sda_oe, 0);
        mode      = 0;
        bus_model = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_mid_ready", cmd_ready, 1);
        nd = 0;
        repeat (100) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("rst_mid_no_done", nd, 0);
        // Bus ownership must have been dropped by the reset
        do_cmd(1, 8'h11, 1'b0, 1'b0, 1'b0, "post_rst_wr");
        check_bus("seq_post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_i2c_byte_master
`default_nettype wire
